// File: rtl/fp_pkg.sv
// Shared single-precision field layout and helpers for the FPU pipeline stages.
package fp_pkg;

  localparam int FP_BIAS     = 127;
  localparam int FP_EXP_W    = 8;
  localparam int FP_MAN_W    = 23;

  // Packed-result field positions
  localparam int FP_SIGN_POS = 31;
  localparam int FP_EXP_MSB  = 30;
  localparam int FP_EXP_LSB  = 23;
  localparam int FP_MAN_MSB  = 22;

  // Derived widths: full mantissa product, exponent sum, signed working exponent
  localparam int FP_PROD_W   = 2 * (FP_MAN_W + 1);
  localparam int FP_ESUM_W   = FP_EXP_W + 1;
  localparam int FP_EXPI_W   = FP_EXP_W + 2;

  // Stage A payload: raw product plus everything stage B needs to finish
  typedef struct packed {
    logic                 sign;
    logic [FP_ESUM_W-1:0] exp_sum;
    logic                 zero;
    logic [FP_PROD_W-1:0] prod;
  } fp_mul_a_t;

  // Stage B payload: packed result and its flags
  typedef struct packed {
    logic [31:0] result;
    logic        ovf;
    logic        unf;
  } fp_mul_res_t;

  function automatic logic [31:0] fp_pack(input logic                s,
                                          input logic [FP_EXP_W-1:0] e,
                                          input logic [FP_MAN_W-1:0] m);
    logic [31:0] r;
    r                          = '0;
    r[FP_SIGN_POS]             = s;
    r[FP_EXP_MSB:FP_EXP_LSB]   = e;
    r[FP_MAN_MSB:0]            = m;
    return r;
  endfunction

endpackage

// File: rtl/fp_norm_round.sv
// Normalize, round-to-nearest-even and pack a 48-bit mantissa product.
// Purely combinational; flush-to-zero on underflow, infinity on overflow.
module fp_norm_round
  import fp_pkg::*;
#(
  parameter int BIAS = FP_BIAS
) (
  input  logic [FP_PROD_W-1:0] prod_i,
  input  logic                 sign_i,
  input  logic [FP_ESUM_W-1:0] exp_sum_i,
  input  logic                 zero_i,
  output logic [31:0]          result_o,
  output logic                 overflow_o,
  output logic                 underflow_o
);

  localparam int PM = FP_PROD_W - 1;
  localparam logic signed [FP_EXPI_W-1:0] BIAS_HI = FP_EXPI_W'(BIAS - 1);
  localparam logic signed [FP_EXPI_W-1:0] BIAS_LO = FP_EXPI_W'(BIAS);
  localparam logic signed [FP_EXPI_W-1:0] EXP_MAX = FP_EXPI_W'((1 << FP_EXP_W) - 1);

  logic                        hi;
  logic [FP_MAN_W-1:0]         man;
  logic                        guard;
  logic                        sticky;
  logic                        inc;
  logic                        carry;
  logic [FP_MAN_W-1:0]         man_r;
  logic signed [FP_EXPI_W-1:0] exp_n;
  logic signed [FP_EXPI_W-1:0] exp_r;

  // Pick the mantissa window by the product's leading bit, then round and pack
  always_comb begin
    hi = prod_i[PM];
    if (hi) begin
      man    = prod_i[PM-1 -: FP_MAN_W];
      guard  = prod_i[PM-1-FP_MAN_W];
      sticky = |prod_i[PM-2-FP_MAN_W:0];
    end else begin
      man    = prod_i[PM-2 -: FP_MAN_W];
      guard  = prod_i[PM-2-FP_MAN_W];
      sticky = |prod_i[PM-3-FP_MAN_W:0];
    end

    // A leading 1 at bit 47 means the product is in [2,4): one less bias
    exp_n = $signed({1'b0, exp_sum_i}) - (hi ? BIAS_HI : BIAS_LO);

    inc            = guard & (sticky | man[0]);
    {carry, man_r} = {1'b0, man} + {{FP_MAN_W{1'b0}}, inc};
    // Mantissa all-ones rolling over already wraps man_r to zero
    exp_r          = exp_n + $signed({{(FP_EXPI_W-1){1'b0}}, carry});

    result_o    = fp_pack(sign_i, exp_r[FP_EXP_W-1:0], man_r);
    overflow_o  = 1'b0;
    underflow_o = 1'b0;
    if (zero_i) begin
      result_o = '0;
    end else if (exp_r >= EXP_MAX) begin
      result_o   = fp_pack(sign_i, {FP_EXP_W{1'b1}}, '0);
      overflow_o = 1'b1;
    end else if (exp_r <= 0) begin
      result_o    = fp_pack(sign_i, '0, '0);
      underflow_o = 1'b1;
    end
  end

endmodule

// File: rtl/mul_p2.sv
// Two-stage single-precision mantissa multiplier back end with valid/ready
// flow control. Stage A holds the raw 24x24 product; stage B holds the
// normalized, rounded and packed result.
module mul_p2
  import fp_pkg::*;
#(
  parameter int BIAS = FP_BIAS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 sign,
  input  logic [FP_ESUM_W-1:0] exp_sum,
  input  logic [FP_MAN_W:0]    mant_a,
  input  logic [FP_MAN_W:0]    mant_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          result,
  output logic                 overflow,
  output logic                 underflow
);

  fp_mul_a_t   a_d, a_q;
  fp_mul_res_t b_d, b_q;
  logic        a_vld_q;
  logic        b_vld_q;
  logic        b_adv;
  logic        a_adv;

  // B moves when it is empty or being drained; A moves whenever B does
  assign b_adv    = !b_vld_q || out_ready;
  assign a_adv    = b_adv;
  assign in_ready = !a_vld_q || a_adv;

  // Stage A payload: inline multiply, zero flag from a missing implicit 1
  always_comb begin
    a_d.sign    = sign;
    a_d.exp_sum = exp_sum;
    a_d.zero    = !mant_a[FP_MAN_W] || !mant_b[FP_MAN_W];
    a_d.prod    = FP_PROD_W'(mant_a) * FP_PROD_W'(mant_b);
  end

  // Stage A register: capture on handshake, empty when A moves with no input
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_vld_q <= 1'b0;
      a_q     <= '0;
    end else if (in_ready) begin
      a_vld_q <= in_valid;
      if (in_valid) a_q <= a_d;
    end
  end

  fp_norm_round #(.BIAS(BIAS)) u_norm (
    .prod_i      (a_q.prod),
    .sign_i      (a_q.sign),
    .exp_sum_i   (a_q.exp_sum),
    .zero_i      (a_q.zero),
    .result_o    (b_d.result),
    .overflow_o  (b_d.ovf),
    .underflow_o (b_d.unf)
  );

  // Stage B register: holds its result steady while downstream stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b_vld_q <= 1'b0;
      b_q     <= '0;
    end else if (b_adv) begin
      b_vld_q <= a_vld_q;
      if (a_vld_q) b_q <= b_d;
    end
  end

  assign out_valid = b_vld_q;
  assign result    = b_q.result;
  assign overflow  = b_q.ovf;
  assign underflow = b_q.unf;

endmodule

// File: tb/tb_mul_p2.sv
// Self-checking bench for mul_p2: directed spec cases, stall, reset, and
// randomized traffic against an arithmetic reference model.
module tb_mul_p2;

  localparam int BIAS = 127;

  logic        clk       = 1'b0;
  logic        rst       = 1'b1;
  logic        in_valid  = 1'b0;
  logic        in_ready;
  logic        sign      = 1'b0;
  logic [8:0]  exp_sum   = '0;
  logic [23:0] mant_a    = '0;
  logic [23:0] mant_b    = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic        overflow;
  logic        underflow;

  int          n_cmp = 0;
  int          n_err = 0;
  int          n_out = 0;
  logic [33:0] exp_q[$];
  logic        hold_v = 1'b0;
  logic [33:0] hold_val = '0;
  logic [33:0] last_obs = '0;

  mul_p2 #(.BIAS(BIAS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sign      (sign),
    .exp_sum   (exp_sum),
    .mant_a    (mant_a),
    .mant_b    (mant_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  // Reference: exact value P * 2^(exp_sum-BIAS-46), rounded to 24 significant
  // bits by remainder-vs-half comparison. Returns {result, ovf, unf}.
  function automatic logic [33:0] model(input logic s, input logic [8:0] es,
                                        input logic [23:0] a, input logic [23:0] b);
    longint p, q, rem, half;
    int     sh, e;
    if (a < 24'h800000 || b < 24'h800000) return 34'h0;
    p    = longint'(a) * longint'(b);
    sh   = (p >= (longint'(1) << 47)) ? 24 : 23;
    q    = p >> sh;
    rem  = p - (q << sh);
    half = longint'(1) << (sh - 1);
    if (rem > half || (rem == half && (q % 2) == 1)) q = q + 1;
    e = int'(es) - BIAS + (sh - 23);
    if (q == (longint'(1) << 24)) begin
      q = q >> 1;
      e = e + 1;
    end
    if (e >= 255) return {s, 8'hFF, 23'h0, 2'b10};
    if (e <= 0)   return {s, 31'h0, 2'b01};
    return {s, e[7:0], q[22:0], 2'b00};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    n_cmp++;
    assert (obs === want) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  task automatic drive(input logic v, input logic s, input logic [8:0] es,
                       input logic [23:0] a, input logic [23:0] b);
    in_valid = v;
    sign     = s;
    exp_sum  = es;
    mant_a   = a;
    mant_b   = b;
  endtask

  task automatic rnd_drive(input logic v);
    logic [23:0] a, b;
    int          k;
    k = $urandom_range(0, 9);
    a = {1'b1, 23'($urandom)};
    b = {1'b1, 23'($urandom)};
    if (k == 0) a = 24'($urandom_range(0, 24'h7FFFFF));
    if (k == 1) b = 24'($urandom_range(0, 24'h7FFFFF));
    if (k == 2) begin a = 24'hFFFFFF; b = {1'b1, 23'($urandom_range(0, 3))}; end
    drive(v, 1'($urandom), 9'($urandom), a, b);
  endtask

  // One cycle: called just after a negedge with inputs set; checks the
  // output side, scores any accept, then moves to the next negedge.
  task automatic step(input string tag, output logic acc);
    logic [33:0] obs, want;
    #1;
    obs = {result, overflow, underflow};
    if (hold_v) chk({tag, " hold"}, 64'({out_valid, obs}), 64'({1'b1, hold_val}));
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk({tag, " spurious"}, 64'(out_valid), 64'd0);
      end else begin
        want = exp_q.pop_front();
        chk({tag, " result"}, 64'(obs), 64'(want));
        last_obs = obs;
        n_out++;
      end
    end
    hold_v   = out_valid && !out_ready;
    hold_val = obs;
    acc      = in_valid && in_ready;
    if (acc) exp_q.push_back(model(sign, exp_sum, mant_a, mant_b));
    @(posedge clk);
    @(negedge clk);
  endtask

  // Single set into an idle pipe: checks latency and a spec-given constant
  task automatic one(input string tag, input logic s, input logic [8:0] es,
                     input logic [23:0] a, input logic [23:0] b, input logic [33:0] want);
    logic acc;
    int   cyc, n0;
    out_ready = 1'b1;
    drive(1'b1, s, es, a, b);
    n0 = n_out;
    step(tag, acc);
    chk({tag, " accept"}, 64'(acc), 64'd1);
    drive(1'b0, 1'b0, 9'd0, 24'd0, 24'd0);
    cyc = 0;
    while (n_out == n0 && cyc < 8) begin
      step(tag, acc);
      cyc++;
    end
    chk({tag, " latency"}, 64'(cyc), 64'd2);
    chk({tag, " const"}, 64'(last_obs), 64'(want));
  endtask

  task automatic drain(input string tag);
    logic acc;
    int   cyc;
    drive(1'b0, 1'b0, 9'd0, 24'd0, 24'd0);
    out_ready = 1'b1;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 20) begin
      step(tag, acc);
      cyc++;
    end
    chk({tag, " drained"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    logic        acc;
    int          idx, n0, cyc;
    logic [23:0] sa[3];

    // Reset state, before any clock edge
    #2;
    chk("reset state", 64'({out_valid, in_ready, result, overflow, underflow}),
        64'({1'b0, 1'b1, 32'h0, 1'b0, 1'b0}));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post-reset ready", 64'({in_ready, out_valid}), 64'({1'b1, 1'b0}));
    @(negedge clk);

    // Directed values
    one("1.5*2.0",   1'b0, 9'd255, 24'hC00000, 24'h800000, {32'h40400000, 2'b00});
    one("1.5*1.5",   1'b0, 9'd254, 24'hC00000, 24'hC00000, {32'h40100000, 2'b00});
    one("overflow",  1'b1, 9'd508, 24'h800000, 24'h800000, {32'hFF800000, 2'b10});
    one("underflow", 1'b0, 9'd2,   24'h800000, 24'h800000, {32'h00000000, 2'b01});
    one("zero",      1'b1, 9'd300, 24'h000000, 24'h800000, {32'h00000000, 2'b00});
    one("round-carry", 1'b0, 9'd200, 24'hFFFFFF, 24'h800001,
        model(1'b0, 9'd200, 24'hFFFFFF, 24'h800001));

    // Back-to-back throughput: every offer must be taken
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rnd_drive(1'b1);
      step("b2b", acc);
      chk("b2b accept", 64'(acc), 64'd1);
    end
    drain("b2b");

    // Stall: three sets offered with downstream blocked
    sa[0] = 24'hC00000; sa[1] = 24'hA00000; sa[2] = 24'hE00000;
    out_ready = 1'b0;
    idx = 0;
    n0  = n_out;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b0, 9'd260, sa[idx], 24'h900000);
      step("stall", acc);
      if (acc) idx++;
    end
    chk("stall accepts", 64'(idx), 64'd2);
    #1;
    chk("stall in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    hold_v = 1'b0;
    out_ready = 1'b1;
    cyc = 0;
    while (idx < 3 && cyc < 10) begin
      drive(1'b1, 1'b0, 9'd260, sa[idx], 24'h900000);
      step("stall", acc);
      if (acc) idx++;
      cyc++;
    end
    drain("stall");
    chk("stall count", 64'(n_out - n0), 64'd3);

    // Randomized traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      rnd_drive(1'($urandom_range(0, 3) != 0));
      out_ready = ($urandom_range(0, 3) != 0);
      step("random", acc);
    end
    drain("random");

    // Reset with two sets in flight
    out_ready = 1'b1;
    rnd_drive(1'b1);
    step("rst fill", acc);
    rnd_drive(1'b1);
    step("rst fill", acc);
    drive(1'b0, 1'b0, 9'd0, 24'd0, 24'd0);
    #1;
    chk("rst in flight", 64'(out_valid), 64'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("rst async", 64'({out_valid, in_ready, result, overflow, underflow}),
        64'({1'b0, 1'b1, 32'h0, 1'b0, 1'b0}));
    exp_q.delete();
    hold_v = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) step("post-rst idle", acc);
    one("post-rst", 1'b0, 9'd254, 24'hC00000, 24'hC00000, {32'h40100000, 2'b00});
    drain("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mul_p2.md
MUL_P2 -- requirements
Module: mul_p2

Interface
REQ-001 SHALL provide parameter BIAS, default 127, the IEEE 754 single-precision exponent bias.
REQ-002 SHALL provide port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL provide port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL provide port in_valid  input  1  the upstream operand set is valid this cycle.
REQ-005 SHALL provide port in_ready  output  1  the block accepts an operand set this cycle.
REQ-006 SHALL provide port sign  input  1  result sign, XOR of operand signs.
REQ-007 SHALL provide port exp_sum  input  9  unbiased sum of the two biased exponents.
REQ-008 SHALL provide ports mant_a and mant_b  input  24 each  mantissas including the implicit 1; a zero value marks a special or zeroed operand.
REQ-009 SHALL provide port out_valid  output  1  result holds a valid product.
REQ-010 SHALL provide port out_ready  input  1  downstream accepts the result this cycle.
REQ-011 SHALL provide port result  output  32  packed IEEE 754 single-precision product.
REQ-012 SHALL provide ports overflow and underflow  output  1 each  flags qualified by out_valid.

Function
REQ-013 SHALL be a 2-stage pipeline: stage A registers the 48-bit product P = mant_a*mant_b with sign, exp_sum and a zero flag; stage B registers the normalized, rounded and packed result.
REQ-014 SHALL have latency 2: an operand set accepted at edge N appears on result at edge N+2 when there is no stall.
REQ-015 SHALL accept input only on in_valid && in_ready; stage A advances when stage B is empty or out_ready=1; in_ready = !A_valid || A_advances.
REQ-016 SHALL keep result, flags and out_valid stable while out_valid=1 and out_ready=0; no transfer is dropped or duplicated.
REQ-017 SHALL sustain one result per cycle with in_valid=out_ready=1; a simultaneous accept and drain in the same cycle is legal at both stages.
REQ-018 SHALL normalize as follows: if P[47]=1, mantissa = P[46:24], guard = P[23], sticky = OR(P[22:0]), and exponent = exp_sum-(BIAS-1); otherwise mantissa = P[45:23], guard = P[22], sticky = OR(P[21:0]), and exponent = exp_sum-BIAS.
REQ-019 SHALL compute the exponent in 10-bit signed arithmetic.
REQ-020 SHALL round to nearest even: increment when guard && (sticky || mantissa LSB); a carry out of the mantissa clears it to 0 and increments the exponent.
REQ-021 SHALL, when the final exponent is >= 255, output {sign,8'hFF,23'h0} with overflow=1.
REQ-022 SHALL, when the final exponent is <= 0, output {sign,31'h0} with underflow=1 (flush to zero, no denormals).
REQ-023 SHALL, when mant_a[23]=0 or mant_b[23]=0, output 32'h00000000 with both flags 0, overriding REQ-021 and REQ-022.
REQ-024 SHALL otherwise output {sign, exponent[7:0], mantissa}.

Reset
REQ-025 SHALL, on rst=1, clear both stage valid bits, out_valid, result, overflow and underflow to 0 immediately, without waiting for clk.
REQ-026 SHALL drive in_ready=1 during and after reset.
REQ-027 SHALL discard any operand sets in flight when reset is asserted mid-operation; the first result after deassertion comes only from operands accepted afterwards.

Structure
REQ-028 SHALL take BIAS, the exponent width (8), the mantissa width (23) and the packed-result field positions from the shared package fp_pkg, which the other FPU stages also use.
REQ-029 SHALL place normalize, round and pack in one combinational sub-module, fp_norm_round, instantiated in stage B; the 24x24 multiply stays inline in stage A.

Verification
REQ-030 SHALL cover 1.5*2.0: sign=0, exp_sum=255, mant_a=24'hC00000, mant_b=24'h800000 -> result=32'h40400000 two cycles later, flags 0.
REQ-031 SHALL cover 1.5*1.5: exp_sum=254, both mantissas 24'hC00000 -> result=32'h40100000 (P[47] normalize path).
REQ-032 SHALL cover overflow and underflow: sign=1, exp_sum=508, mantissas 24'h800000 -> 32'hFF800000 with overflow=1; sign=0, exp_sum=2 -> 32'h00000000 with underflow=1.
REQ-033 SHALL cover zero: mant_a=0, exp_sum=300 -> 32'h00000000 with both flags 0.
REQ-034 SHALL cover stall: out_ready=0 while three sets are offered -> in_ready drops after two accepts and the results drain in order once out_ready=1, with none lost or repeated.
REQ-035 SHALL cover reset: rst pulsed with two sets in flight -> out_valid=0 at once and no stale result appears after release.
